edge_period_meter: RTL and testbench
====================================

Name: edge_period_meter

Overview:
- Controller that sequences a measurement window over the single-cycle `rising_edge` pulses produced by the receiver's synchronizing edge detector.
- On `start`, it waits for an arming edge, then counts `clk` cycles spanning `N_EDGES` further edges. It reports the total cycle count, the number of edges captured, and a timeout flag.
- It sits between the edge detector and the receiver's frequency/lock logic, and owns arming, watchdog and result handshaking.

Parameters:
- N_EDGES, 16: number of edges after the arming edge that close the window; legal range >= 1.
- CNT_W, 24: width of the cycle counter and `period_count`.
- TIMEOUT_CYC, 65535: maximum cycles allowed without an edge while armed or measuring; legal range >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a measurement; sampled in IDLE only.
- abort  in  1  cancels an armed or active measurement.
- edge_in  in  1  single-cycle edge pulse, already synchronous to clk.
- busy  out  1  high while in ARM or MEASURE.
- done  out  1  one-cycle pulse when a result (normal or timeout) is valid.
- timeout  out  1  result flag: watchdog expired; held until next start.
- period_count  out  CNT_W  clk cycles from arming edge to final edge; held until next start.
- edge_count  out  $clog2(N_EDGES+1)  edges captured after the arming edge; held until next start.

Behaviour:
- Reset (synchronous, `rst`=1 at posedge):
  - state=IDLE.
  - busy, done, timeout = 0; period_count, edge_count = 0.
  - Internal cycle counter and watchdog cleared.
- States: IDLE, ARM, MEASURE. Results are registered outputs; there is no separate DONE state.
- IDLE:
  - start=1 and abort=0 -> ARM next cycle.
  - On that same transition: busy<=1; timeout, period_count, edge_count <= 0; watchdog <= 0.
  - start=1 with abort=1 -> stay IDLE (abort wins).
- ARM:
  - edge_in=1 -> MEASURE; cycle counter <= 1; watchdog <= 0.
  - Otherwise watchdog increments.
- MEASURE:
  - Cycle counter increments every cycle, saturating at 2^CNT_W-1 with no wrap.
  - edge_in=1 -> edge_count+1 and watchdog <= 0.
  - On the edge that makes edge_count == N_EDGES:
    - period_count <= current counter value; with period P, the result is N_EDGES*P.
    - state <= IDLE, busy <= 0, done <= 1.
  - done is therefore high exactly one cycle, in the cycle after the final edge. busy falls in that same cycle.
- Watchdog (ARM or MEASURE):
  - When watchdog reaches TIMEOUT_CYC-1 with no edge in that cycle -> IDLE with done<=1, timeout<=1, period_count<=0.
  - edge_count keeps the number of edges captured so far.
  - An edge and watchdog expiry in the same cycle -> the edge wins and the watchdog restarts.
- abort=1 in ARM or MEASURE -> IDLE next cycle; busy<=0; done not pulsed; timeout=0; period_count and edge_count keep their partial values.
- abort has priority over edge and timeout in the same cycle.
- start is ignored while busy=1.
- start asserted in the cycle done=1 (state IDLE) is accepted normally. done still completes its pulse, and result outputs clear on the ARM transition.
- edge_in high on consecutive cycles counts as separate edges; no filtering.
- rst asserted mid-measurement -> immediate return to reset values; no done pulse.

Test Plan:
- Nominal (N_EDGES=4, TIMEOUT_CYC=100): start, edges every 10 cycles -> period_count=40, edge_count=4, timeout=0; done high 1 cycle, the cycle after the 5th edge overall; busy low the same cycle.
- No edge (TIMEOUT_CYC=100): start, edge_in held 0 -> done and timeout=1 exactly 100 cycles after ARM entry; edge_count=0, period_count=0.
- Partial timeout: arming edge plus 2 edges at 10-cycle spacing, then silence -> timeout=1, edge_count=2, period_count=0; edge arriving on the expiry cycle instead restarts the watchdog and no timeout occurs.
- Abort: abort after 2 edges in MEASURE -> IDLE next cycle, busy=0, no done, edge_count=2; start+abort together in IDLE -> remains IDLE.
- Saturation (CNT_W=6, N_EDGES=2, edges every 40 cycles) -> period_count=63.
- Back-to-back and reset: start on the done cycle re-arms immediately and results clear; rst mid-MEASURE -> all outputs 0 next cycle; start during busy is ignored.

Source files
------------

// File: rtl/edge_period_meter.sv
// -----------------------------------------------------------------------------
// edge_period_meter
//
// Sequences a measurement window over single-cycle edge pulses coming out of
// the receiver's synchronizing edge detector. After `start` the block waits
// for an arming edge, then counts clk cycles until N_EDGES further edges have
// been seen. A watchdog aborts the window with a timeout result if the edge
// stream goes quiet for TIMEOUT_CYC cycles.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   start         begin a measurement (only looked at while idle)
//   abort         cancel an armed or running measurement, no result pulse
//   edge_in       single-cycle edge pulse, synchronous to clk
//   busy          high while armed or measuring
//   done          one-cycle pulse when a result (normal or timeout) is valid
//   timeout       result flag: watchdog expired (held until next start)
//   period_count  clk cycles from arming edge to final edge (held)
//   edge_count    edges captured after the arming edge (held)
// -----------------------------------------------------------------------------
module edge_period_meter #(
    parameter int N_EDGES     = 16,
    parameter int CNT_W       = 24,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             edge_in,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout,
    output logic [CNT_W-1:0]                 period_count,
    output logic [$clog2(N_EDGES+1)-1:0]     edge_count
);

    localparam int ECW  = $clog2(N_EDGES + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    // Edge count value that, with one more edge, closes the window.
    localparam logic [ECW-1:0]   ECNT_LAST = ECW'(N_EDGES - 1);
    localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WD_W-1:0]    wd_q,      wd_d;
    logic               done_q,    done_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   period_q,  period_d;
    logic [ECW-1:0]     ecnt_q,    ecnt_d;

    logic               wd_expire;
    logic [CNT_W-1:0]   cnt_inc;

    // Watchdog expiry only matters when no edge arrives in the same cycle;
    // the edge branches below are checked first so the edge wins.
    assign wd_expire = (wd_q == WD_LAST);

    // Cycle counter saturates instead of wrapping so a very slow input reads
    // as "at least full scale" rather than a small bogus period.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wd_q      <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            period_q  <= '0;
            ecnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wd_q      <= wd_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            period_q  <= period_d;
            ecnt_q    <= ecnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // Priority inside a busy state: abort, then edge, then watchdog expiry.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wd_d      = wd_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        period_d  = period_q;
        ecnt_d    = ecnt_q;

        case (state_q)
            IDLE: begin
                // Results are held here until the next accepted start,
                // which clears them on the way into ARM.
                if (start && !abort) begin
                    state_d   = ARM;
                    timeout_d = 1'b0;
                    period_d  = '0;
                    ecnt_d    = '0;
                    wd_d      = '0;
                end
            end

            ARM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (edge_in) begin
                    // Arming edge: the cycle after it counts as cycle 1.
                    state_d = MEASURE;
                    cnt_d   = CNT_ONE;
                    wd_d    = '0;
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    period_d  = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end

            MEASURE: begin
                if (abort) begin
                    // Partial edge count is kept; period stays at the 0
                    // written on entry to ARM.
                    state_d = IDLE;
                end else if (edge_in) begin
                    ecnt_d = ecnt_q + 1'b1;
                    wd_d   = '0;
                    cnt_d  = cnt_inc;
                    if (ecnt_q == ECNT_LAST) begin
                        // Current count spans arming edge to this final edge.
                        period_d = cnt_q;
                        state_d  = IDLE;
                        done_d   = 1'b1;
                    end
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    period_d  = '0;
                end else begin
                    wd_d  = wd_q + 1'b1;
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign timeout      = timeout_q;
    assign period_count = period_q;
    assign edge_count   = ecnt_q;

endmodule

// File: tb/tb_edge_period_meter.sv
// -----------------------------------------------------------------------------
// tb_edge_period_meter
//
// Drives directed and random edge streams into edge_period_meter and checks
// busy/done every cycle plus the held results against a reference model that
// works out the outcome of a whole measurement from its list of edge times.
// Time t = 0 is the first cycle the block spends armed.
// -----------------------------------------------------------------------------
module tb_edge_period_meter;

    localparam int N    = 4;
    localparam int CW   = 6;
    localparam int T    = 100;
    localparam int MAXC = (1 << CW) - 1;
    localparam int ECW  = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           abort;
    logic           edge_in;
    logic           busy;
    logic           done;
    logic           timeout;
    logic [CW-1:0]  period_count;
    logic [ECW-1:0] edge_count;

    int n_chk = 0;
    int n_err = 0;

    // Stimulus for one measurement: edge times (ascending) and abort time.
    int edg_q[$];
    int abort_t;

    edge_period_meter #(
        .N_EDGES     (N),
        .CNT_W       (CW),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .edge_in      (edge_in),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .period_count (period_count),
        .edge_count   (edge_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Outcome of one measurement from the rules:
    //  - first edge must come within T-1 cycles of arming (edge on the
    //    expiry cycle still counts);
    //  - later edges may be up to T cycles apart (watchdog restarts the
    //    cycle after each edge);
    //  - abort beats everything on its cycle;
    //  - period = final edge time - arming edge time, saturated.
    task automatic model(output int end_t, output bit ab, output bit tmo,
                         output int cap, output int per);
        int deadline;
        int t0;
        deadline = T - 1;
        t0       = 0;
        end_t    = -1;
        ab       = 1'b0;
        tmo      = 1'b0;
        cap      = 0;
        per      = 0;
        for (int i = 0; i < edg_q.size(); i++) begin
            int e;
            e = edg_q[i];
            if (abort_t >= 0 && abort_t <= e && abort_t <= deadline) begin
                end_t = abort_t; ab = 1'b1; return;
            end
            if (e > deadline) begin
                end_t = deadline; tmo = 1'b1; return;
            end
            if (i == 0) t0 = e;
            else        cap++;
            if (cap == N) begin
                end_t = e;
                per   = (e - t0 > MAXC) ? MAXC : e - t0;
                return;
            end
            deadline = e + T;
        end
        if (abort_t >= 0 && abort_t <= deadline) begin
            end_t = abort_t; ab = 1'b1;
        end else begin
            end_t = deadline; tmo = 1'b1;
        end
    endtask

    // Run one measurement from IDLE. With hold_done the task returns in the
    // done cycle so the caller can issue a back-to-back start.
    task automatic run_txn(input string tag, input bit hold_done);
        int end_t, cap, per, qi;
        bit ab, tmo;
        model(end_t, ab, tmo, cap, per);
        qi = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".arm_busy"},    busy, 1);
        chk({tag, ".arm_done"},    done, 0);
        chk({tag, ".arm_tmo"},     timeout, 0);
        chk({tag, ".arm_period"},  period_count, 0);
        chk({tag, ".arm_edges"},   edge_count, 0);
        for (int t = 0; t <= end_t; t++) begin
            edge_in = (qi < edg_q.size() && edg_q[qi] == t);
            if (edge_in) qi++;
            abort = (t == abort_t);
            start = 1'($urandom_range(0, 1));   // must be ignored while busy
            @(posedge clk); #1;
            edge_in = 1'b0;
            abort   = 1'b0;
            start   = 1'b0;
            chk({tag, ".busy"}, busy, (t < end_t) ? 1 : 0);
            chk({tag, ".done"}, done, (t == end_t && !ab) ? 1 : 0);
        end
        chk({tag, ".timeout"}, timeout, tmo ? 1 : 0);
        chk({tag, ".period"},  period_count, per);
        chk({tag, ".edges"},   edge_count, cap);
        if (!hold_done) begin
            @(posedge clk); #1;
            chk({tag, ".done_drop"},   done, 0);
            chk({tag, ".idle_busy"},   busy, 0);
            chk({tag, ".period_hold"}, period_count, per);
            chk({tag, ".edges_hold"},  edge_count, cap);
        end
    endtask

    task automatic set_edges(input int a, input int b, input int c, input int d, input int e);
        edg_q.delete();
        if (a >= 0) edg_q.push_back(a);
        if (b >= 0) edg_q.push_back(b);
        if (c >= 0) edg_q.push_back(c);
        if (d >= 0) edg_q.push_back(d);
        if (e >= 0) edg_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; edge_in = 1'b0; abort_t = -1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy",    busy, 0);
        chk("rst.done",    done, 0);
        chk("rst.timeout", timeout, 0);
        chk("rst.period",  period_count, 0);
        chk("rst.edges",   edge_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal: edges every 10 cycles -> 4*10 cycles.
        abort_t = -1; set_edges(3, 13, 23, 33, 43);
        run_txn("nominal", 1'b0);

        // No edges: timeout 100 cycles after arming.
        abort_t = -1; set_edges(-1, -1, -1, -1, -1);
        run_txn("noedge", 1'b0);

        // Arming edge plus two, then silence.
        abort_t = -1; set_edges(0, 10, 20, -1, -1);
        run_txn("partial_tmo", 1'b0);

        // Arming edge exactly on the expiry cycle wins.
        abort_t = -1; set_edges(T - 1, T + 9, T + 19, T + 29, T + 39);
        run_txn("arm_edge_on_expiry", 1'b0);

        // Measure-phase edge exactly on the expiry cycle wins.
        abort_t = -1; set_edges(0, 10, 20, 20 + T, 30 + T);
        run_txn("meas_edge_on_expiry", 1'b0);

        // Abort after two edges in MEASURE.
        abort_t = 25; set_edges(0, 10, 20, 30, 40);
        run_txn("abort_meas", 1'b0);

        // Abort on the same cycle as an edge: abort wins.
        abort_t = 20; set_edges(0, 10, 20, 30, 40);
        run_txn("abort_on_edge", 1'b0);

        // start and abort together in IDLE: stays idle.
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort.busy", busy, 0);
        @(posedge clk); #1;
        chk("start_abort.busy2", busy, 0);

        // Saturation: 80-cycle window on a 6-bit counter.
        abort_t = -1; set_edges(0, 20, 40, 60, 80);
        run_txn("saturate", 1'b0);

        // Back-to-back: start issued in the done cycle.
        abort_t = -1; set_edges(2, 7, 12, 17, 22);
        run_txn("b2b_first", 1'b1);
        abort_t = -1; set_edges(1, 4, 5, 6, 9);
        run_txn("b2b_second", 1'b0);

        // Reset mid-measurement.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 10; t++) begin
            edge_in = (t == 0 || t == 5);
            @(posedge clk); #1;
            edge_in = 1'b0;
        end
        chk("midrst.pre_edges", edge_count, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst.busy",    busy, 0);
        chk("midrst.done",    done, 0);
        chk("midrst.timeout", timeout, 0);
        chk("midrst.period",  period_count, 0);
        chk("midrst.edges",   edge_count, 0);
        @(posedge clk); #1;
        chk("midrst.done2",   done, 0);

        // Random measurements.
        for (int k = 0; k < 25; k++) begin
            int n, tm;
            edg_q.delete();
            n  = $urandom_range(0, 5);
            tm = $urandom_range(0, 110);
            for (int i = 0; i < n; i++) begin
                edg_q.push_back(tm);
                tm += ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30)
                                                  : $urandom_range(1, 105);
            end
            abort_t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 200)) : -1;
            run_txn($sformatf("rand%0d", k), ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
